dm_bus_arbiter: RTL and testbench

Round-robin arbiter and transfer sequencer that shares the single data-memory port of the multicore matrix-multiplication processor between the per-core datapaths. Each core raises a request carrying an address, a write flag and write data. The arbiter grants exactly one core at a time, drives the shared memory port, waits the fixed memory latency, and returns read data with a one-cycle completion pulse. It sits between the cores' bus/register datapaths and the shared data memory.

---
 rtl/dm_bus_arbiter_if.sv | 31 +++
 rtl/dm_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dm_bus_arbiter_if.sv
// rtl/dm_bus_arbiter_if.sv - core request/grant bus and shared data-memory port
interface dm_bus_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16
);
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*DATA_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;
  logic                        mem_en;
  logic                        mem_we;
  logic [DATA_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  // Cores plus data memory: drive requests and read data, observe the arbiter.
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter: consumes requests and read data, drives grants and the memory port.
  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_bus_arbiter.sv
// rtl/dm_bus_arbiter.sv - shares the data-memory port between cores, one transaction at a time
// Optional feature macro: DM_ARB_FIXED_PRIO_EN (lowest requesting index wins, no rotation pointer).
module dm_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 1
) (
  input logic             clk,
  input logic             rst,
  dm_bus_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   we_q, we_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [DATA_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

  logic                   found;
  logic [IDX_W-1:0]       win;

`ifdef DM_ARB_FIXED_PRIO_EN
  // Winner search: lowest requesting index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W:0]         cand;

  // Winner search: first requester at or above ptr, wrapping past the top core.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CORES)) begin
        cand = cand - (IDX_W+1)'(NUM_CORES);
      end
      if (!found && bus.req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end
`endif

  // Next-state and registered-output logic; request fields are frozen at grant.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifndef DM_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ACCESS;
          idx_d       = win;
          we_d        = bus.we[win];
          gnt_d       = NUM_CORES'(1) << win;
          busy_d      = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.we[win];
          mem_addr_d  = bus.addr[win*DATA_W +: DATA_W];
          mem_wdata_d = bus.wdata[win*DATA_W +: DATA_W];
        end
      end
      ACCESS: begin
        state_d  = WAIT;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = NUM_CORES'(1) << idx_q;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
`ifndef DM_ARB_FIXED_PRIO_EN
        ptr_d   = (idx_q == IDX_W'(NUM_CORES - 1)) ? '0 : idx_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifndef DM_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb/tb_dm_bus_arbiter.sv - directed bench for dm_bus_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_dm_bus_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dm_bus_arbiter_if #(.NUM_CORES(4), .DATA_W(16)) bus_a ();
  dm_bus_arbiter_if #(.NUM_CORES(4), .DATA_W(16)) bus_b ();

  dm_bus_arbiter #(.NUM_CORES(4), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dm_bus_arbiter #(.NUM_CORES(4), .DATA_W(16), .MEM_LAT(3)) u_dut_lat3 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus_a.we[c]             = w;
    bus_a.addr[c*16 +: 16]  = a;
    bus_a.wdata[c*16 +: 16] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(bus_a.gnt),       32'h0);
    chk({tag, "_done"},   32'(bus_a.done),      32'h0);
    chk({tag, "_busy"},   32'(bus_a.busy),      32'h0);
    chk({tag, "_mem_en"}, 32'(bus_a.mem_en),    32'h0);
    chk({tag, "_mem_we"}, 32'(bus_a.mem_we),    32'h0);
    chk({tag, "_maddr"},  32'(bus_a.mem_addr),  32'h0);
    chk({tag, "_mwdata"}, 32'(bus_a.mem_wdata), 32'h0);
    chk({tag, "_rdata"},  32'(bus_a.rdata),     32'h0);
  endtask

  logic [3:0] exp_gnt [5];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.mem_rdata = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.mem_rdata = '0;
    #3;
    chk_all_zero("reset");
    tick;
    rst = 1'b0;

    // Single read: core 1, addr 0x0010, memory returns 0xBEEF.
    set_core(1, 1'b0, 16'h0010, 16'h0000);
    bus_a.req = 4'b0010;
    tick; // t+1
    bus_a.req = 4'b0000;
    chk("rd_gnt1",   32'(bus_a.gnt),      32'h2);
    chk("rd_busy1",  32'(bus_a.busy),     32'h1);
    chk("rd_men1",   32'(bus_a.mem_en),   32'h1);
    chk("rd_mwe1",   32'(bus_a.mem_we),   32'h0);
    chk("rd_maddr1", 32'(bus_a.mem_addr), 32'h0010);
    tick; // t+2
    bus_a.mem_rdata = 16'hBEEF;
    chk("rd_gnt2",   32'(bus_a.gnt),      32'h2);
    chk("rd_men2",   32'(bus_a.mem_en),   32'h0);
    chk("rd_done2",  32'(bus_a.done),     32'h0);
    tick; // t+3
    bus_a.mem_rdata = 16'hDEAD;
    chk("rd_gnt3",   32'(bus_a.gnt),      32'h2);
    chk("rd_done3",  32'(bus_a.done),     32'h2);
    chk("rd_rdata3", 32'(bus_a.rdata),    32'hBEEF);
    tick; // t+4
    chk("rd_gnt4",   32'(bus_a.gnt),      32'h0);
    chk("rd_busy4",  32'(bus_a.busy),     32'h0);
    chk("rd_done4",  32'(bus_a.done),     32'h0);
    chk("rd_rdata4", 32'(bus_a.rdata),    32'hBEEF);

    // Single write: core 3 writes 0x1234 to 0x0020; rdata must not change.
    set_core(3, 1'b1, 16'h0020, 16'h1234);
    bus_a.req = 4'b1000;
    tick; // t+1
    bus_a.req = 4'b0000;
    chk("wr_gnt1",   32'(bus_a.gnt),       32'h8);
    chk("wr_men1",   32'(bus_a.mem_en),    32'h1);
    chk("wr_mwe1",   32'(bus_a.mem_we),    32'h1);
    chk("wr_maddr1", 32'(bus_a.mem_addr),  32'h0020);
    chk("wr_mwd1",   32'(bus_a.mem_wdata), 32'h1234);
    tick; // t+2
    bus_a.mem_rdata = 16'h5555;
    chk("wr_men2",   32'(bus_a.mem_en),    32'h0);
    chk("wr_mwe2",   32'(bus_a.mem_we),    32'h0);
    tick; // t+3
    chk("wr_done3",  32'(bus_a.done),      32'h8);
    chk("wr_rdata3", 32'(bus_a.rdata),     32'hBEEF);
    tick; // t+4
    chk("wr_busy4",  32'(bus_a.busy),      32'h0);
    set_core(3, 1'b0, 16'h0000, 16'h0000);

    // Core 2 drops req and changes addr during ACCESS.
    set_core(2, 1'b0, 16'h0030, 16'h0000);
    bus_a.req = 4'b0100;
    tick; // t+1
    bus_a.req = 4'b0000;
    set_core(2, 1'b1, 16'h0999, 16'hFFFF);
    chk("drop_gnt1",   32'(bus_a.gnt),      32'h4);
    chk("drop_maddr1", 32'(bus_a.mem_addr), 32'h0030);
    tick; // t+2
    bus_a.mem_rdata = 16'h0A0A;
    chk("drop_maddr2", 32'(bus_a.mem_addr), 32'h0030);
    chk("drop_gnt2",   32'(bus_a.gnt),      32'h4);
    tick; // t+3
    chk("drop_done3",  32'(bus_a.done),     32'h4);
    chk("drop_rdata3", 32'(bus_a.rdata),    32'h0A0A);
    tick; // t+4
    chk("drop_gnt4",   32'(bus_a.gnt),      32'h0);
    set_core(2, 1'b0, 16'h0000, 16'h0000);

    // Reset mid-WAIT aborts the core 0 read with no done pulse.
    set_core(0, 1'b0, 16'h0011, 16'h0000);
    bus_a.req = 4'b0001;
    tick; // t+1
    bus_a.req = 4'b0000;
    chk("abort_gnt1", 32'(bus_a.gnt), 32'h1);
    tick; // t+2 (WAIT)
    bus_a.mem_rdata = 16'h7777;
    chk("abort_busy2", 32'(bus_a.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    tick;
    chk("abort_done", 32'(bus_a.done), 32'h0);
    chk("abort_gnt",  32'(bus_a.gnt),  32'h0);
    rst = 1'b0;

    // After reset release, core 2 read completes normally.
    set_core(2, 1'b0, 16'h0040, 16'h0000);
    bus_a.req = 4'b0100;
    tick; // t+1
    bus_a.req = 4'b0000;
    chk("post_gnt1",  32'(bus_a.gnt),      32'h4);
    chk("post_maddr", 32'(bus_a.mem_addr), 32'h0040);
    tick; // t+2
    bus_a.mem_rdata = 16'hC0DE;
    tick; // t+3
    chk("post_done3",  32'(bus_a.done),  32'h4);
    chk("post_rdata3", 32'(bus_a.rdata), 32'hC0DE);
    tick;
    chk("post_busy4", 32'(bus_a.busy), 32'h0);

    // Full contention with req=1111 held from reset.
`ifdef DM_ARB_FIXED_PRIO_EN
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b0001;
    exp_gnt[3] = 4'b0001; exp_gnt[4] = 4'b0001;
`else
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
`endif
    rst = 1'b1;
    bus_a.req = 4'b1111;
    tick;
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick;
        chk($sformatf("cont_g%0d_c%0d_gnt", g, c), 32'(bus_a.gnt),
            (c < 3) ? 32'(exp_gnt[g]) : 32'h0);
        chk($sformatf("cont_g%0d_c%0d_onehot", g, c), 32'($countones(bus_a.gnt) <= 1), 32'h1);
        chk($sformatf("cont_g%0d_c%0d_done", g, c), 32'(bus_a.done),
            (c == 2) ? 32'(exp_gnt[g]) : 32'h0);
      end
    end
    bus_a.req = 4'b0000;

    // MEM_LAT=3 instance: core 0 read, done at t+5, rdata sampled in t+4.
    tick;
    bus_b.addr[15:0] = 16'h0050;
    bus_b.req = 4'b0001;
    tick; // t+1
    bus_b.req = 4'b0000;
    chk("lat3_gnt1",  32'(bus_b.gnt),      32'h1);
    chk("lat3_men1",  32'(bus_b.mem_en),   32'h1);
    chk("lat3_maddr", 32'(bus_b.mem_addr), 32'h0050);
    tick; // t+2
    bus_b.mem_rdata = 16'h1111;
    chk("lat3_men2", 32'(bus_b.mem_en), 32'h0);
    tick; // t+3
    bus_b.mem_rdata = 16'h2222;
    chk("lat3_done3", 32'(bus_b.done), 32'h0);
    tick; // t+4
    bus_b.mem_rdata = 16'h3333;
    chk("lat3_done4", 32'(bus_b.done), 32'h0);
    tick; // t+5
    bus_b.mem_rdata = 16'h4444;
    chk("lat3_done5",  32'(bus_b.done),  32'h1);
    chk("lat3_rdata5", 32'(bus_b.rdata), 32'h3333);
    chk("lat3_gnt5",   32'(bus_b.gnt),   32'h1);
    tick; // t+6
    chk("lat3_gnt6",   32'(bus_b.gnt),   32'h0);
    chk("lat3_done6",  32'(bus_b.done),  32'h0);
    chk("lat3_rdata6", 32'(bus_b.rdata), 32'h3333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
